// File: rtl/imem_fetch_server.sv
// Instruction-fetch responder: owns the instruction store, answers one fetch at a
// time after a fixed latency, and flags misaligned / out-of-range PCs instead of data.
module imem_fetch_server #(
   parameter int unsigned WORDS_LOG2 = 11,
   parameter logic [31:0] BASE       = 32'h0000_3000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_kill_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_instr_o,
   output logic [31:0] rsp_addr_o,
   output logic [1:0]  rsp_fault_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic [3:0]  wr_be_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [31:0] SPAN        = 32'(1) << (WORDS_LOG2 + 2);
   localparam logic [1:0]  CNT_INIT    = 2'(LATENCY - 1);
   localparam state_e      ACCEPT_NEXT = (LATENCY == 1) ? S_RESP : S_WAIT;

   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE) && ((a - BASE) < SPAN);
   endfunction

   function automatic logic [WORDS_LOG2-1:0] word_idx(input logic [31:0] a);
      return WORDS_LOG2'((a - BASE) >> 2);
   endfunction

   logic [31:0] mem [2**WORDS_LOG2];

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rsp_instr_q;
   logic [31:0] rsp_addr_q;
   logic [1:0]  rsp_fault_q;

   logic        accept;
   logic [1:0]  req_fault;
   logic        wr_ok;

   assign req_fault = {~in_range(req_addr_i), req_addr_i[1:0] != 2'b00};
   assign wr_ok     = wr_en_i && (wr_addr_i[1:0] == 2'b00) && in_range(wr_addr_i);

   // In RESP a new request rides on the response handshake; a kill blocks acceptance everywhere.
   assign req_ready_o = !req_kill_i &&
                        ((state_q == S_IDLE) ||
                         ((state_q == S_RESP) && rsp_ready_i && req_valid_i));
   assign accept      = req_valid_i && req_ready_o;

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: ;
         S_WAIT: begin
            if (req_kill_i) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = 2'(cnt_q - 2'd1);
               if (cnt_q == 2'd1) state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (req_kill_i)       state_d = S_IDLE;
            else if (rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         state_d = ACCEPT_NEXT;
         cnt_d   = CNT_INIT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         rsp_instr_q <= 32'd0;
         rsp_addr_q  <= 32'd0;
         rsp_fault_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            rsp_addr_q  <= req_addr_i;
            rsp_fault_q <= req_fault;
            rsp_instr_q <= (req_fault != 2'b00) ? 32'd0 : mem[word_idx(req_addr_i)];
         end
      end
   end

   // NOTE: the memory array has no reset so it maps onto RAM and keeps its contents across a reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) mem[word_idx(wr_addr_i)][8*b +: 8] <= wr_data_i[8*b +: 8];
         end
      end
   end

   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_instr_o = rsp_instr_q;
   assign rsp_addr_o  = rsp_addr_q;
   assign rsp_fault_o = rsp_fault_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_fetch_server.sv
// Self-checking bench for imem_fetch_server: directed scenarios followed by randomized
// fetches and writes, checked against an array-based reference of the instruction store.
module tb_imem_fetch_server;

   localparam int          LATENCY = 2;
   localparam logic [31:0] BASE    = 32'h0000_3000;
   localparam int          WORDS   = 2048;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_kill;
   logic [31:0] req_addr;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_instr, rsp_addr;
   logic [1:0]  rsp_fault;
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_be;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [31:0] ref_mem [WORDS];

   imem_fetch_server #(.WORDS_LOG2(11), .BASE(BASE), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_addr_i (req_addr),
      .req_kill_i (req_kill),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_instr_o(rsp_instr),
      .rsp_addr_o (rsp_addr),
      .rsp_fault_o(rsp_fault),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .wr_be_i    (wr_be),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fault(input logic [31:0] a);
      longint unsigned lo, hi;
      logic [1:0] f;
      lo = BASE;
      hi = longint'(BASE) + 4 * WORDS - 1;
      f[0] = (a % 4) != 0;
      f[1] = (a < lo) || (a > hi);
      return f;
   endfunction

   function automatic logic [31:0] ref_instr(input logic [31:0] a);
      if (ref_fault(a) != 2'b00) return 32'd0;
      return ref_mem[(a - BASE) / 4];
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int idx;
      if (ref_fault(a) == 2'b00) begin
         idx = (a - BASE) / 4;
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      @(negedge clk);
      wr_en = 1'b0;
      ref_write(a, d, be);
   endtask

   // Counts negedges from the acceptance edge until rsp_valid, bounded.
   task automatic wait_rsp(output int n);
      n = 1;
      while (!rsp_valid && n < 16) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic fetch(input logic [31:0] a, input int stall, input string tag);
      logic [31:0] e_instr;
      logic [1:0]  e_fault;
      int n;
      e_instr = ref_instr(a);
      e_fault = ref_fault(a);
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; rsp_ready = (stall == 0);
      #1 check({tag, ":req_ready"}, req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(n);
      check({tag, ":latency"}, n, LATENCY);
      check({tag, ":instr"}, rsp_instr, e_instr);
      check({tag, ":addr"}, rsp_addr, a);
      check({tag, ":fault"}, rsp_fault, e_fault);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, ":hold_valid"}, rsp_valid, 1);
         check({tag, ":hold_instr"}, rsp_instr, e_instr);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check({tag, ":idle_after"}, busy, 0);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 5))
         0, 1, 2: return BASE + 4 * $urandom_range(0, 15);
         3:       return BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
         4:       return BASE - 4 * $urandom_range(1, 100) + $urandom_range(0, 3);
         default: return BASE + 32'd8192 + $urandom_range(0, 400);
      endcase
   endfunction

   initial begin
      logic [31:0] e_instr;
      int n;

      for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_kill = 1'b0; rsp_ready = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      repeat (2) @(negedge clk);
      check("reset:rsp_valid", rsp_valid, 0);
      check("reset:busy", busy, 0);
      check("reset:rsp_instr", rsp_instr, 0);
      check("reset:rsp_addr", rsp_addr, 0);
      check("reset:rsp_fault", rsp_fault, 0);
      check("reset:req_ready", req_ready, 1);
      reset = 1'b0;

      // Preload the region used by the bench so no read depends on uninitialised storage.
      for (int i = 0; i < 16; i++) mem_write(BASE + 4 * i, $urandom, 4'hF);
      mem_write(32'h0000_4FFC, 32'hCAFE_F00D, 4'hF);

      // Basic fetch
      mem_write(32'h0000_3000, 32'h2408_0001, 4'hF);
      fetch(32'h0000_3000, 0, "t1");
      check("t1:const_instr", ref_instr(32'h0000_3000), 32'h2408_0001);

      // Byte-enable merge
      mem_write(32'h0000_3004, 32'h1111_1111, 4'hF);
      mem_write(32'h0000_3004, 32'h0000_AB00, 4'b0010);
      fetch(32'h0000_3004, 0, "t2_merge");
      check("t2:const_instr", rsp_instr, 32'h1111_AB11);

      // Write on the acceptance edge must not affect the fetched word
      e_instr = ref_instr(32'h0000_3004);
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_3004;
      wr_en = 1'b1; wr_addr = 32'h0000_3004; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
      @(negedge clk);
      req_valid = 1'b0; wr_en = 1'b0;
      ref_write(32'h0000_3004, 32'hDEAD_BEEF, 4'hF);
      wait_rsp(n);
      check("t2_rbw:latency", n, LATENCY);
      check("t2_rbw:instr_old", rsp_instr, e_instr);
      @(negedge clk);
      fetch(32'h0000_3004, 0, "t2_new");

      // Fault classification
      fetch(32'h0000_3002, 0, "t3_misaligned");
      fetch(32'h0000_2FFC, 0, "t3_below");
      fetch(32'h0000_5001, 0, "t3_both");
      fetch(32'h0000_4FFC, 0, "t3_last");
      check("t3:last_fault_const", rsp_fault, 2'b00);

      // Backpressure then back-to-back issue
      mem_write(32'h0000_3008, 32'h0123_4567, 4'hF);
      e_instr = ref_instr(32'h0000_3000);
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_3000; rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(n);
      check("t4:latency", n, LATENCY);
      req_valid = 1'b1; req_addr = 32'h0000_3008;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t4:req_ready_low", req_ready, 0);
         check("t4:valid_held", rsp_valid, 1);
         check("t4:instr_held", rsp_instr, e_instr);
         check("t4:addr_held", rsp_addr, 32'h0000_3000);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1 check("t4:b2b_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(n);
      check("t4:b2b_latency", n, LATENCY);
      check("t4:b2b_instr", rsp_instr, 32'h0123_4567);
      check("t4:b2b_addr", rsp_addr, 32'h0000_3008);
      @(negedge clk);
      check("t4:idle_after", busy, 0);

      // Kill while waiting
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_3000;
      @(negedge clk);
      req_kill = 1'b1; req_addr = 32'h0000_3008;
      #1 check("t5:ready_in_kill", req_ready, 0);
      @(negedge clk);
      req_kill = 1'b0; req_valid = 1'b0;
      check("t5:busy_after_kill", busy, 0);
      for (int i = 0; i < LATENCY + 1; i++) begin
         check("t5:no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      fetch(32'h0000_3008, 0, "t5_next");

      // Reset in WAIT
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_3000;
      @(negedge clk);
      req_valid = 1'b0;
      check("t6:busy_before_reset", busy, 1);
      reset = 1'b1;
      #1;
      check("t6:rsp_valid_reset", rsp_valid, 0);
      check("t6:busy_reset", busy, 0);
      check("t6:rsp_addr_reset", rsp_addr, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < LATENCY + 1; i++) begin
         @(negedge clk);
         check("t6:no_rsp", rsp_valid, 0);
      end
      fetch(32'h0000_3000, 0, "t6_retained");
      check("t6:const_instr", rsp_instr, 32'h2408_0001);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1)
            mem_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)));
         fetch(rand_addr(), $urandom_range(0, 3), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
